// File: rtl/ft232h_rx_reader.sv
// rtl/ft232h_rx_reader.sv - FT232H sync-245 FIFO receive path into an AXI-Stream master
//
// Purpose: requests ADBUS ownership, turns the bus around, strobes rd_n to pull
// PC-to-FPGA bytes out of the FT232H RX FIFO, buffers them locally and presents
// them on an AXI-Stream master. A read tenure ends when the FT232H runs dry or
// after MAX_BURST bytes, and a one-cycle RELEASE gives the bus back.
//
// Ports:
//   ftdi_clk   in   60 MHz FT232H clock (only clock)
//   rst        in   synchronous active-high reset
//   rxf_n      in   FT232H RX FIFO has data (active low)
//   data_in    in   ADBUS input path
//   oe_n       out  FT232H output enable (active low)
//   rd_n       out  FT232H read strobe (active low)
//   rd_active  out  high while this block owns or is releasing ADBUS
//   arb_req    out  ADBUS ownership request
//   arb_grant  in   ADBUS ownership grant
//   tdata      out  received byte
//   tvalid     out  AXIS valid
//   tready     in   AXIS ready
module ft232h_rx_reader #(
  parameter int BUF_DEPTH = 4,
  parameter int MAX_BURST = 64
) (
  input  logic       ftdi_clk,
  input  logic       rst,
  input  logic       rxf_n,
  input  logic [7:0] data_in,
  output logic       oe_n,
  output logic       rd_n,
  output logic       rd_active,
  output logic       arb_req,
  input  logic       arb_grant,
  output logic [7:0] tdata,
  output logic       tvalid,
  input  logic       tready
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {S_IDLE, S_TURN, S_READ, S_REL} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_oe_n, r_rd_n, r_rd_active, r_arb_req;
  logic          w_oe_n_nxt, w_rd_n_nxt, w_rd_active_nxt, w_arb_req_nxt;
  logic [7:0]    r_mem [BUF_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [OW-1:0] r_cnt;
  logic [7:0]    r_tdata;
  logic          r_tvalid;
  logic [BW-1:0] r_burst, w_burst_nxt;
  logic          w_push, w_pop, w_load, w_burst_max, w_rd_ok;
  logic [OW:0]   w_occ, w_occ_nxt;

  // A byte is only valid on an edge where our strobe was low and the FT232H
  // still reports data; rxf_n high means data_in is garbage.
  assign w_push = (r_state == S_READ) && !r_rd_n && !rxf_n;
  assign w_pop  = r_tvalid && tready;
  // The output register refills from the buffer one cycle after a capture.
  assign w_load = (r_cnt != '0) && (!r_tvalid || tready);

  // Occupancy counts every byte held, including the one on tdata.
  assign w_occ     = {1'b0, r_cnt} + (OW+1)'(r_tvalid);
  assign w_occ_nxt = w_occ + (OW+1)'(w_push) - (OW+1)'(w_pop);

  assign w_burst_nxt = (w_push && (r_burst != BW'(MAX_BURST))) ? r_burst + BW'(1) : r_burst;
  assign w_burst_max = (w_burst_nxt == BW'(MAX_BURST));
  // Strobe only when the next byte is certain to have a slot and burst budget.
  assign w_rd_ok = !rxf_n && (w_occ_nxt <= (OW+1)'(BUF_DEPTH - 1)) && !w_burst_max;

  always_ff @(posedge ftdi_clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (r_arb_req && arb_grant && !rxf_n && (w_occ < (OW+1)'(BUF_DEPTH)))
                w_state_nxt = S_TURN;
      S_TURN: w_state_nxt = rxf_n ? S_REL : S_READ;
      S_READ: if (rxf_n || w_burst_max) w_state_nxt = S_REL;
      S_REL:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered bus outputs, derived from the next state.
  always_comb begin
    w_oe_n_nxt      = !((w_state_nxt == S_TURN) || (w_state_nxt == S_READ));
    w_rd_n_nxt      = !((w_state_nxt == S_READ) && w_rd_ok);
    w_rd_active_nxt = (w_state_nxt != S_IDLE);
    // Leaving RELEASE forces a low cycle so the TX path can win arbitration.
    if (r_state == S_IDLE) w_arb_req_nxt = !rxf_n;
    else                   w_arb_req_nxt = (w_state_nxt == S_TURN) || (w_state_nxt == S_READ);
  end

  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      r_oe_n      <= 1'b1;
      r_rd_n      <= 1'b1;
      r_rd_active <= 1'b0;
      r_arb_req   <= 1'b0;
      r_burst     <= '0;
    end else begin
      r_oe_n      <= w_oe_n_nxt;
      r_rd_n      <= w_rd_n_nxt;
      r_rd_active <= w_rd_active_nxt;
      r_arb_req   <= w_arb_req_nxt;
      r_burst     <= (r_state == S_REL) ? '0 : w_burst_nxt;
    end
  end

  always_ff @(posedge ftdi_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_in;
  end

  always_ff @(posedge ftdi_clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_tdata  <= 8'h00;
      r_tvalid <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_load) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_cnt <= r_cnt + OW'(w_push) - OW'(w_load);
      if (w_load) begin
        r_tdata  <= r_mem[r_rd_ptr];
        r_tvalid <= 1'b1;
      end else if (w_pop) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign oe_n      = r_oe_n;
  assign rd_n      = r_rd_n;
  assign rd_active = r_rd_active;
  assign arb_req   = r_arb_req;
  assign tdata     = r_tdata;
  assign tvalid    = r_tvalid;
endmodule
